bird_physics: RTL and testbench
===============================

// Module: bird_physics
// PURPOSE
//  Bird vertical-motion engine; consumes game_FSM's one-hot game_state and the flap button, produces the collision input game_FSM consumes.
//  Integrates gravity/flap impulse once per frame_tick while IN_GAME; freezes in PAUSE/END_SCREEN; re-arms in START_SCREEN.
//  Sits between input conditioning, game_FSM and the pixel renderer (bird_y drives sprite row).
// PARAMETERS
//  Y_W          10   width of bird_y (unsigned pixels, 0 = top of screen)
//  VEL_W        6    width of bird_vel (signed two's complement, +ve = downward)
//  SCREEN_H     480  visible rows
//  BIRD_H       16   sprite height; FLOOR_Y = SCREEN_H-BIRD_H = 464
//  START_Y      232  spawn row
//  GRAVITY      1    velocity increment per frame_tick
//  FLAP_IMPULSE 8    flap sets velocity to -FLAP_IMPULSE
//  MAX_FALL     10   terminal downward velocity (saturation)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      reset; asynchronous, active-low
//  frame_tick  in   1      one-cycle strobe per video frame
//  game_state  in   4      one-hot {END_SCREEN,PAUSE,IN_GAME,START_SCREEN}
//  flap        in   1      flap button level (already synchronised)
//  bird_y      out  Y_W    bird top row
//  bird_vel    out  VEL_W  current signed velocity
//  collision   out  1      floor hit; level, to game_FSM
// BEHAVIOUR
//  Reset (rst=0, async): bird_y=START_Y, bird_vel=0, collision=0, flap_pending=0, flap_prev=0.
//  Flap edge: flap_prev registers flap every cycle; rise = flap & ~flap_prev.
//   IN_GAME: rise sets flap_pending; pending held until next frame_tick, then cleared.
//   Rise in same cycle as frame_tick is applied at that tick.
//   Any other state: rises discarded, flap_pending forced 0.
//  START_SCREEN: bird_y<=START_Y, bird_vel<=0, collision<=0 every cycle.
//  PAUSE, END_SCREEN, non-one-hot game_state: all registers hold (treated as freeze).
//  IN_GAME, frame_tick=1, collision=0 (all updates registered, visible 1 cycle after tick):
//   v_new = flap_pending ? -FLAP_IMPULSE : min(bird_vel+GRAVITY, MAX_FALL).
//   y_new = bird_y + v_new evaluated signed at Y_W+2 bits (no wrap).
//   y_new < 0        -> bird_y=0, bird_vel=0 (ceiling clamp, not a collision).
//   y_new >= FLOOR_Y -> bird_y=FLOOR_Y, bird_vel=0, collision=1.
//   else             -> bird_y=y_new, bird_vel=v_new.
//  collision=1: sticky; further ticks ignored until START_SCREEN or reset.
//  IN_GAME without frame_tick: only flap_pending may change.
//  Reset mid-fall: all outputs return to reset values immediately.
// STRUCTURE
//  game_pkg: state bit indices (START_SCREEN=0, IN_GAME=1, PAUSE=2, END_SCREEN=3), screen constants.
//  Sub-module: rising_edge_detector (flap -> rise pulse); physics update inline.
// TESTING
//  Reset release -> bird_y=232, bird_vel=0, collision=0.
//  IN_GAME, 3 ticks no flap -> bird_vel 1,2,3; bird_y 233,235,238.
//  Flap rise mid-frame at y=238 -> next tick bird_vel=-8, bird_y=230; pending cleared.
//  Free fall from 232 -> bird_vel saturates at 10; bird_y=464, collision=1, held through END_SCREEN ticks; START_SCREEN -> 232/0/0.
//  Flap at bird_y=5 -> bird_y=0, bird_vel=0, collision=0.
//  PAUSE + 5 ticks + flap rises -> y/vel unchanged, flap_pending=0; async reset mid-fall -> reset values same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-level constants: one-hot game_state bit positions and screen geometry.
package game_pkg;

  // Bit positions inside the one-hot game_state bus driven by game_FSM
  localparam int ST_START_SCREEN = 0;
  localparam int ST_IN_GAME      = 1;
  localparam int ST_PAUSE        = 2;
  localparam int ST_END_SCREEN   = 3;

  // Legal one-hot encodings of game_state
  typedef enum logic [3:0] {
    GS_START_SCREEN = 4'b0001,
    GS_IN_GAME      = 4'b0010,
    GS_PAUSE        = 4'b0100,
    GS_END_SCREEN   = 4'b1000
  } game_state_e;

  // Screen geometry in pixels
  localparam int SCREEN_H_PX = 480;
  localparam int BIRD_H_PX   = 16;

endpackage

// File: rtl/rising_edge_detector.sv
// Single-cycle pulse on each 0->1 transition of an already-synchronised level.
module rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_prev;

  // Remember last cycle's level so a rise is seen exactly once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_prev <= 1'b0;
    end else begin
      sig_prev <= sig;
    end
  end

  assign rise = sig & ~sig_prev;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical-motion engine: integrates gravity / flap impulse once per frame while
// in game, clamps at the ceiling, and raises a sticky collision on reaching the floor.
module bird_physics
  import game_pkg::*;
#(
  parameter int Y_W          = 10,
  parameter int VEL_W        = 6,
  parameter int SCREEN_H     = SCREEN_H_PX,
  parameter int BIRD_H       = BIRD_H_PX,
  parameter int START_Y      = 232,
  parameter int GRAVITY      = 1,
  parameter int FLAP_IMPULSE = 8,
  parameter int MAX_FALL     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic [3:0]              game_state,
  input  logic                    flap,
  output logic [Y_W-1:0]          bird_y,
  output logic signed [VEL_W-1:0] bird_vel,
  output logic                    collision
);

  localparam int FLOOR_Y = SCREEN_H - BIRD_H;
  localparam int YW2     = Y_W + 2;

  localparam logic signed [VEL_W:0]   GRAV_S  = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   MAXF_S  = (VEL_W+1)'(MAX_FALL);
  localparam logic signed [VEL_W-1:0] FLAP_V  = VEL_W'(-FLAP_IMPULSE);
  localparam logic signed [YW2-1:0]   FLOOR_S = YW2'(FLOOR_Y);

  logic                    flap_rise;
  logic                    flap_pending;
  logic                    is_start;
  logic                    is_game;
  logic                    flap_now;
  logic signed [VEL_W-1:0] v_new;
  logic signed [YW2-1:0]   y_new;

  // Gravity step with saturation at terminal downward velocity; the extra bit keeps
  // bird_vel + GRAVITY from wrapping before the comparison.
  function automatic logic signed [VEL_W-1:0] sat_fall(input logic signed [VEL_W-1:0] v);
    logic signed [VEL_W:0] s;
    s = $signed({v[VEL_W-1], v}) + GRAV_S;
    if (s > MAXF_S) return MAXF_S[VEL_W-1:0];
    return s[VEL_W-1:0];
  endfunction

  rising_edge_detector u_flap_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (flap),
    .rise (flap_rise)
  );

  // Only exact one-hot codes act; anything else (PAUSE, END_SCREEN, illegal) freezes.
  assign is_start = (game_state == GS_START_SCREEN);
  assign is_game  = (game_state == GS_IN_GAME);
  // A rise coinciding with the tick is honoured at that same tick
  assign flap_now = flap_pending | flap_rise;

  // Next velocity and position, position widened by two bits so ceiling and floor
  // overshoot are visible as out-of-range values rather than wrapping.
  always_comb begin
    v_new = flap_now ? FLAP_V : sat_fall(bird_vel);
    y_new = $signed({2'b00, bird_y}) + {{(YW2-VEL_W){v_new[VEL_W-1]}}, v_new};
  end

  // Flap latch and bird state update, one physics step per frame tick while in game
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flap_pending <= 1'b0;
      bird_y       <= Y_W'(START_Y);
      bird_vel     <= '0;
      collision    <= 1'b0;
    end else begin
      flap_pending <= is_game & ~frame_tick & flap_now;
      if (is_start) begin
        bird_y    <= Y_W'(START_Y);
        bird_vel  <= '0;
        collision <= 1'b0;
      end else if (is_game && frame_tick && !collision) begin
        if (y_new[YW2-1]) begin
          bird_y   <= '0;
          bird_vel <= '0;
        end else if (y_new >= FLOOR_S) begin
          bird_y    <= Y_W'(FLOOR_Y);
          bird_vel  <= '0;
          collision <= 1'b1;
        end else begin
          bird_y   <= y_new[Y_W-1:0];
          bird_vel <= v_new;
        end
      end
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// Scoreboard bench for bird_physics: a behavioural model pushes expected
// {bird_y, bird_vel, collision} for every driven cycle; results are popped after the edge.
module tb_bird_physics;

  localparam logic [3:0] S_START = 4'b0001;
  localparam logic [3:0] S_GAME  = 4'b0010;
  localparam logic [3:0] S_PAUSE = 4'b0100;
  localparam logic [3:0] S_END   = 4'b1000;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic [3:0]        game_state;
  logic              flap;
  logic [9:0]        bird_y;
  logic signed [5:0] bird_vel;
  logic              collision;

  typedef struct {
    int y;
    int vel;
    int col;
  } exp_t;

  exp_t sb[$];
  int   m_y, m_vel, m_col, m_pend, m_prev;
  int   n_checks = 0;
  int   n_errors = 0;

  bird_physics dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .game_state (game_state),
    .flap       (flap),
    .bird_y     (bird_y),
    .bird_vel   (bird_vel),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 232; m_vel = 0; m_col = 0; m_pend = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic [3:0] st, input bit tick, input bit fl);
    int rise, eff, v, yn;
    rise   = (fl && !m_prev) ? 1 : 0;
    m_prev = fl;
    if (st == S_START) begin
      m_y = 232; m_vel = 0; m_col = 0; m_pend = 0;
    end else if (st == S_GAME) begin
      eff = m_pend | rise;
      if (tick) begin
        m_pend = 0;
        if (!m_col) begin
          if (eff) v = -8;
          else v = (m_vel + 1 > 10) ? 10 : m_vel + 1;
          yn = m_y + v;
          if (yn < 0) begin
            m_y = 0; m_vel = 0;
          end else if (yn >= 464) begin
            m_y = 464; m_vel = 0; m_col = 1;
          end else begin
            m_y = yn; m_vel = v;
          end
        end
      end else begin
        m_pend = eff;
      end
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic cycle(input string tag, input logic [3:0] st, input bit tick, input bit fl);
    exp_t e;
    game_state = st;
    frame_tick = tick;
    flap       = fl;
    model_step(st, tick, fl);
    sb.push_back('{m_y, m_vel, m_col});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".y"},   int'(bird_y),   e.y);
    check({tag, ".vel"}, int'(bird_vel), e.vel);
    check({tag, ".col"}, int'(collision), e.col);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; frame_tick = 1'b0; flap = 1'b0; game_state = S_START;
    model_reset();
    #12;
    check("rst.y", int'(bird_y), 232);
    check("rst.vel", int'(bird_vel), 0);
    check("rst.col", int'(collision), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    repeat (2) cycle("start", S_START, 0, 0);

    // Three gravity ticks
    for (int i = 0; i < 3; i++) begin
      cycle("fall", S_GAME, 1, 0);
      cycle("idle", S_GAME, 0, 0);
    end
    check("fall3.vel", int'(bird_vel), 3);
    check("fall3.y", int'(bird_y), 238);

    // Flap rise mid-frame, applied at the following tick
    cycle("fl_rise", S_GAME, 0, 1);
    cycle("fl_low", S_GAME, 0, 0);
    cycle("fl_low", S_GAME, 0, 0);
    cycle("fl_tick", S_GAME, 1, 0);
    check("flap.vel", int'(bird_vel), -8);
    check("flap.y", int'(bird_y), 230);
    cycle("fl_after", S_GAME, 1, 0);
    check("pend_clr.vel", int'(bird_vel), -7);

    // Rise in the same cycle as the tick
    cycle("fl_same", S_GAME, 1, 1);
    check("same.vel", int'(bird_vel), -8);
    cycle("fl_rel", S_GAME, 0, 0);

    // Non-one-hot state freezes
    repeat (2) cycle("illegal", 4'b0110, 1, 0);

    // Pause: ticks and flap rises ignored, pending discarded
    for (int i = 0; i < 5; i++) begin
      cycle("pause_fl", S_PAUSE, 1, 1);
      cycle("pause", S_PAUSE, 0, 0);
    end
    cycle("resume", S_GAME, 1, 0);
    check("resume.vel", int'(bird_vel), -7);

    // Free fall to the floor
    cycle("rearm", S_START, 0, 0);
    for (int i = 0; i < 60 && !collision; i++) cycle("ff", S_GAME, 1, 0);
    check("floor.col", int'(collision), 1);
    check("floor.y", int'(bird_y), 464);
    repeat (3) cycle("end", S_END, 1, 1);
    cycle("sticky", S_GAME, 1, 0);
    cycle("sticky_fl", S_GAME, 1, 1);
    cycle("restart", S_START, 0, 0);
    check("restart.y", int'(bird_y), 232);

    // Climb to y=5, then one more flap hits the ceiling
    for (int i = 0; i < 6; i++) cycle("pre", S_GAME, 1, 0);
    for (int i = 0; i < 31; i++) begin
      cycle("climb_r", S_GAME, 0, 1);
      cycle("climb_t", S_GAME, 1, 0);
    end
    check("climb.y", int'(bird_y), 5);
    cycle("ceil_r", S_GAME, 0, 1);
    cycle("ceil_t", S_GAME, 1, 0);
    check("ceil.y", int'(bird_y), 0);
    check("ceil.vel", int'(bird_vel), 0);
    check("ceil.col", int'(collision), 0);

    // Asynchronous reset mid-fall
    for (int i = 0; i < 4; i++) cycle("fall2", S_GAME, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst.y", int'(bird_y), 232);
    check("arst.vel", int'(bird_vel), 0);
    check("arst.col", int'(collision), 0);
    model_reset();
    frame_tick = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle("post_rst", S_GAME, 1, 0);
    check("post_rst.y", int'(bird_y), 233);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
